// File: rtl/bsg_manycore_pkt_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_pkt_rx_ctrl
// Purpose  : Receive-side packet controller for a manycore tile. Buffers
//            packets from the mesh input link in a small circular FIFO,
//            decodes the head packet and routes remote stores to the local
//            memory write port, freeze/unfreeze packets to the core freeze
//            register, and consumes (and optionally counts) unknown ops.
// Options  : `define BSG_MANYCORE_RX_UNKNOWN_CNT_EN builds the 16-bit
//            saturating unknown-op counter; otherwise unknown_cnt_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_manycore_pkt_rx_ctrl #(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 16,
  parameter int fifo_els_p     = 2,
  parameter bit freeze_init_p  = 1'b1,
  localparam int packet_width_lp = 6 + 2*x_cord_width_p + 2*y_cord_width_p
                                   + data_width_p + addr_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                       ready_o,
  output logic                       mem_v_o,
  output logic [addr_width_p-1:0]    mem_addr_o,
  output logic [data_width_p-1:0]    mem_data_o,
  input  logic                       mem_yumi_i,
  output logic                       freeze_o,
  output logic [15:0]                unknown_cnt_o
);

  localparam int ptr_w_lp   = $clog2(fifo_els_p);
  localparam int coord_w_lp = 2*x_cord_width_p + 2*y_cord_width_p;
  // Only op/addr/data are buffered; coordinates are routed upstream and dropped.
  localparam int entry_w_lp = 6 + addr_width_p + data_width_p;
  localparam logic [5:0] op_store_lp  = 6'd1;
  localparam logic [5:0] op_freeze_lp = 6'd2;

  logic [entry_w_lp-1:0]   fifo_mem_q [fifo_els_p];
  logic [ptr_w_lp:0]       rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp:0]       wr_ptr_q, wr_ptr_d;
  logic                    freeze_q, freeze_d;

  logic                    empty, full, enq, deq;
  logic [entry_w_lp-1:0]   head;
  logic [5:0]              head_op;
  logic [addr_width_p-1:0] head_addr;
  logic [data_width_p-1:0] head_data;
  logic                    is_store, is_freeze, is_unknown;
  logic                    unused_coords;

  assign unused_coords = ^data_i[coord_w_lp-1:0];

  assign head      = fifo_mem_q[rd_ptr_q[ptr_w_lp-1:0]];
  assign head_op   = head[entry_w_lp-1 -: 6];
  assign head_addr = head[data_width_p +: addr_width_p];
  assign head_data = head[data_width_p-1:0];

  // FIFO status, head decode, handshakes and next-state values.
  always_comb begin
    empty = (rd_ptr_q == wr_ptr_q);
    // Full: same slot index, opposite lap (wrap bit).
    full  = (rd_ptr_q[ptr_w_lp-1:0] == wr_ptr_q[ptr_w_lp-1:0]) &&
            (rd_ptr_q[ptr_w_lp] != wr_ptr_q[ptr_w_lp]);

    is_store   = !empty && (head_op == op_store_lp);
    is_freeze  = !empty && (head_op == op_freeze_lp) && (head_addr == '0);
    is_unknown = !empty && (head_op != op_store_lp) && (head_op != op_freeze_lp);

    // No bypass: a full FIFO refuses input even when the head leaves this cycle.
    enq = v_i && !full;
    // Stores wait for the memory; everything else leaves in one cycle.
    deq = !empty && (!is_store || mem_yumi_i);

    wr_ptr_d = wr_ptr_q + (ptr_w_lp+1)'(enq);
    rd_ptr_d = rd_ptr_q + (ptr_w_lp+1)'(deq);
    freeze_d = is_freeze ? head_data[0] : freeze_q;
  end

  // Pointer and freeze registers; reset discards every buffered packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      freeze_q <= freeze_init_p;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      freeze_q <= freeze_d;
    end
  end

  // Packet storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= data_i[packet_width_lp-1 -: entry_w_lp];
    end
  end

`ifdef BSG_MANYCORE_RX_UNKNOWN_CNT_EN
  logic [15:0] unknown_cnt_q, unknown_cnt_d;

  // Saturating count of unknown-op packets consumed.
  always_comb begin
    unknown_cnt_d = unknown_cnt_q;
    if (is_unknown && (unknown_cnt_q != 16'hFFFF)) begin
      unknown_cnt_d = unknown_cnt_q + 16'd1;
    end
  end

  // Unknown-op counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      unknown_cnt_q <= '0;
    end else begin
      unknown_cnt_q <= unknown_cnt_d;
    end
  end

  assign unknown_cnt_o = unknown_cnt_q;
`else
  logic unused_unknown;
  assign unused_unknown = is_unknown;
  assign unknown_cnt_o  = 16'h0;
`endif

  assign ready_o    = !full;
  assign mem_v_o    = is_store;
  assign mem_addr_o = head_addr;
  assign mem_data_o = head_data;
  assign freeze_o   = freeze_q;

  // The memory must never accept a write that is not being offered.
  a_yumi_only_when_valid : assert property (
    @(posedge clk_i) disable iff (reset_i) !(mem_yumi_i && !mem_v_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_pkt_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_pkt_rx_ctrl
// Purpose  : Self-checking bench for bsg_manycore_pkt_rx_ctrl. Table of
//            packets with expected freeze/counter outcomes, a store
//            scoreboard fed at acceptance and drained by a memory responder,
//            plus hand sequences for stall, backpressure and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_manycore_pkt_rx_ctrl;

  localparam int PW = 6 + 16 + 32 + 16;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          v_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic          ready_o;
  logic          mem_v_o;
  logic [15:0]   mem_addr_o;
  logic [31:0]   mem_data_o;
  logic          mem_yumi_i = 1'b0;
  logic          freeze_o;
  logic [15:0]   unknown_cnt_o;

  bsg_manycore_pkt_rx_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .mem_v_o      (mem_v_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_yumi_i   (mem_yumi_i),
    .freeze_o     (freeze_o),
    .unknown_cnt_o(unknown_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int model_cnt = 0;
  bit auto_yumi = 1'b0;
  logic [47:0] sb [$];

  typedef struct {
    logic [5:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_freeze;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input logic [5:0] op, input logic [15:0] addr,
                                         input logic [31:0] data);
    return {op, addr, data, 4'h3, 4'h2, 4'h1, 4'h5};
  endfunction

  // Reference counter: saturating when the counter is built, otherwise 0.
  function automatic void bump_unknown();
`ifdef BSG_MANYCORE_RX_UNKNOWN_CNT_EN
    if (model_cnt < 65535) model_cnt++;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with v_i still high.
  task automatic send_pkt(input logic [5:0] op, input logic [15:0] addr, input logic [31:0] data);
    int waited = 0;
    v_i = 1'b1;
    data_i = pack(op, addr, data);
    while (ready_o !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_o stuck at %b required 1", ready_o);
      v_i = 1'b0;
      return;
    end
    if (op == 6'd1) sb.push_back({addr, data});
    else if (op != 6'd2) bump_unknown();
    @(negedge clk);
  endtask

  task automatic idle();
    v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  // Memory responder: randomly accepts offered writes and checks them in order.
  always @(negedge clk) begin
    if (auto_yumi && !reset_i) begin
      mem_yumi_i = 1'b0;
      if (mem_v_o === 1'b1 && $urandom_range(0, 3) != 0) begin
        mem_yumi_i = 1'b1;
        writes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h required none", mem_addr_o, mem_data_o);
        end else begin
          logic [47:0] e;
          e = sb.pop_front();
          chk("wr_addr", 64'(mem_addr_o), 64'(e[47:32]));
          chk("wr_data", 64'(mem_data_o), 64'(e[31:0]));
        end
      end
    end
  end

  initial begin
    int w0;
    vecs[0]  = '{6'd2,  16'h0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{6'd1,  16'h0040, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{6'd7,  16'h0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{6'd2,  16'h0005, 32'h0000_0001, 1'b0};
    vecs[4]  = '{6'd2,  16'h0000, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{6'd0,  16'h0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{6'd1,  16'hFFFF, 32'h1234_5678, 1'b1};
    vecs[7]  = '{6'd2,  16'h0000, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{6'd63, 16'h0000, 32'h0000_0001, 1'b0};
    vecs[9]  = '{6'd2,  16'h0000, 32'h0000_0003, 1'b1};
    vecs[10] = '{6'd1,  16'h0000, 32'h0000_0000, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_mem_v", 64'(mem_v_o), 64'd0);
    chk("rst_freeze", 64'(freeze_o), 64'd1);
    chk("rst_cnt", 64'(unknown_cnt_o), 64'd0);

    // Freeze timing: register changes on the edge after the packet reaches the head
    send_pkt(6'd2, 16'h0, 32'h0);
    idle();
    chk("frz0_head_cycle", 64'(freeze_o), 64'd1);
    @(negedge clk);
    chk("frz0_after", 64'(freeze_o), 64'd0);
    send_pkt(6'd2, 16'h0, 32'h1);
    idle();
    chk("frz1_head_cycle", 64'(freeze_o), 64'd0);
    @(negedge clk);
    chk("frz1_after", 64'(freeze_o), 64'd1);

    // Stalled store held stable until accepted
    send_pkt(6'd1, 16'h0040, 32'hDEADBEEF);
    idle();
    sb.delete();
    for (int i = 0; i < 5; i++) begin
      chk("stall_v", 64'(mem_v_o), 64'd1);
      chk("stall_addr", 64'(mem_addr_o), 64'h0040);
      chk("stall_data", 64'(mem_data_o), 64'hDEADBEEF);
      @(negedge clk);
    end
    mem_yumi_i = 1'b1;
    @(negedge clk);
    mem_yumi_i = 1'b0;
    chk("stall_done_v", 64'(mem_v_o), 64'd0);

    // Table-driven packets with random memory acceptance
    auto_yumi = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send_pkt(vecs[i].op, vecs[i].addr, vecs[i].data);
      idle();
      drain();
      chk($sformatf("vec%0d_freeze", i), 64'(freeze_o), 64'(vecs[i].exp_freeze));
      chk($sformatf("vec%0d_cnt", i), 64'(unknown_cnt_o), 64'(model_cnt));
    end

    // Backpressure: two stores fill the FIFO, the third is held, order kept
    auto_yumi = 1'b0;
    mem_yumi_i = 1'b0;
    send_pkt(6'd1, 16'h00A0, 32'hAAAA_0001);
    send_pkt(6'd1, 16'h00B0, 32'hBBBB_0002);
    data_i = pack(6'd1, 16'h00C0, 32'hCCCC_0003);
    chk("full_ready", 64'(ready_o), 64'd0);
    chk("full_head_addr", 64'(mem_addr_o), 64'h00A0);
    @(negedge clk);
    chk("full_ready_hold", 64'(ready_o), 64'd0);
    w0 = writes;
    auto_yumi = 1'b1;
    send_pkt(6'd1, 16'h00C0, 32'hCCCC_0003);
    idle();
    drain();
    chk("bp_writes", 64'(writes - w0), 64'd3);

    // Unknown ops back to back, then saturation
    w0 = model_cnt;
    send_pkt(6'd7, 16'h0, 32'h0);
    send_pkt(6'd7, 16'h0, 32'h0);
    send_pkt(6'd7, 16'h0, 32'h0);
    idle();
    repeat (3) @(negedge clk);
`ifdef BSG_MANYCORE_RX_UNKNOWN_CNT_EN
    chk("unk_plus3", 64'(unknown_cnt_o), 64'(w0 + 3));
    while (model_cnt < 65535) send_pkt(6'd7, 16'h0, 32'h0);
    send_pkt(6'd7, 16'h0, 32'h0);
    send_pkt(6'd7, 16'h0, 32'h0);
    idle();
    repeat (3) @(negedge clk);
    chk("unk_saturated", 64'(unknown_cnt_o), 64'hFFFF);
`else
    chk("unk_disabled", 64'(unknown_cnt_o), 64'd0);
`endif

    // Reset with two stores buffered: everything discarded, nothing written
    auto_yumi = 1'b0;
    mem_yumi_i = 1'b0;
    send_pkt(6'd2, 16'h0, 32'h0);
    send_pkt(6'd1, 16'h0100, 32'h1111_1111);
    send_pkt(6'd1, 16'h0200, 32'h2222_2222);
    idle();
    repeat (2) @(negedge clk);
    chk("pre_rst_v", 64'(mem_v_o), 64'd1);
    chk("pre_rst_freeze", 64'(freeze_o), 64'd0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("mid_rst_v", 64'(mem_v_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_freeze", 64'(freeze_o), 64'd1);
    chk("mid_rst_cnt", 64'(unknown_cnt_o), 64'd0);
    sb.delete();
    w0 = writes;
    auto_yumi = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_write_after_rst", 64'(writes - w0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
